f1_reaction_ctrl: RTL
=====================

F1_REACTION_CTRL -- requirements
Module: f1_reaction_ctrl

Interface
REQ-001 The module SHALL have parameter TIMEOUT_MS, default 2000, giving the reaction-window limit in ms ticks (1..65534).
REQ-002 The module SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The module SHALL have port start, input, 1, the arm request, already synchronised, level, sampled each cycle.
REQ-005 The module SHALL have port react, input, 1, the driver button, already synchronised, level.
REQ-006 The module SHALL have port tick, input, 1, a one-cycle 1 ms strobe.
REQ-007 The module SHALL have port lights, input, 8, the lamp vector from the light-sequence FSM.
REQ-008 The module SHALL have port trigger, output, 1, the one-cycle start pulse to the light-sequence FSM.
REQ-009 The module SHALL have port reaction_ms, output, 16, the last measured reaction time in ms.
REQ-010 The module SHALL have ports valid, false_start and timeout, output, 1 each, one-cycle result strobes.
REQ-011 The module SHALL have port best_ms, output, 16, the minimum valid reaction time since reset.
REQ-012 The module SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 The module SHALL detect react_rise as react high this cycle and low the previous cycle; only react_rise counts as a press.
REQ-014 The module SHALL implement the states IDLE, ARM, SEQ, HOLD, TIMING, DONE and FOUL.
REQ-015 IDLE SHALL go to ARM when start=1; start SHALL be ignored in all other states.
REQ-016 ARM SHALL drive trigger=1 for exactly one cycle, then go to SEQ; trigger SHALL be 0 in every other state.
REQ-017 SEQ SHALL go to FOUL on react_rise, else to HOLD when lights==8'hFF, else stay.
REQ-018 HOLD SHALL go to FOUL on react_rise, else to TIMING when lights==8'h00, clearing the ms counter to 0 on that transition.
REQ-019 If react_rise and lights==8'h00 occur in the same HOLD cycle, the module SHALL treat it as a false start (FOUL).
REQ-020 TIMING SHALL increment the 16-bit ms counter on each tick.
REQ-021 On react_rise in TIMING, the module SHALL load reaction_ms with counter+tick (a coincident tick is included) and go to DONE.
REQ-022 When counter reaches TIMEOUT_MS without a react_rise in TIMING, the module SHALL load reaction_ms=16'hFFFF, set the timeout flag and go to DONE.
REQ-023 DONE SHALL assert valid for one cycle, plus timeout when REQ-022 applied, then go to IDLE.
REQ-024 FOUL SHALL assert false_start for one cycle, leave reaction_ms unchanged, then go to IDLE.
REQ-025 In DONE without timeout, best_ms SHALL update to min(best_ms, reaction_ms) one cycle after valid; ties SHALL leave it unchanged.
REQ-026 reaction_ms and best_ms SHALL hold their values between updates.

Reset
REQ-027 While rst_n=0, the module SHALL force state IDLE, trigger=0, valid=0, false_start=0, timeout=0, busy=0, reaction_ms=0, best_ms=16'hFFFF, counter=0 and the react history bit=0.
REQ-028 Reset asserted mid-sequence SHALL abort immediately with no result strobe; after release, the module SHALL need a new start.

Structure
REQ-029 The package f1_pkg SHALL hold the state enum typedef, the 16'hFFFF sentinel constant and the default TIMEOUT_MS.
REQ-030 The ms counter with clear, increment-on-tick and compare SHALL be one sub-module, ms_counter; all FSM and result registers SHALL stay in f1_reaction_ctrl.

Verification
REQ-031 Normal run: start pulse, lights ramp to FF then 00, react_rise after 237 ticks -> valid=1 for one cycle, reaction_ms=237, best_ms=237, trigger seen once.
REQ-032 False start: react_rise while lights=8'h07 in SEQ -> false_start=1 for one cycle, reaction_ms and best_ms unchanged, busy=0 the next cycle.
REQ-033 Timeout: TIMEOUT_MS=50, no react -> valid=1, timeout=1, reaction_ms=16'hFFFF on tick 50, best_ms unchanged.
REQ-034 Coincidence: react_rise and lights->00 in the same HOLD cycle -> FOUL; react_rise together with tick at counter=99 -> reaction_ms=100.
REQ-035 Best tracking: runs of 300, 180 and 250 -> best_ms sequence 300, 180, 180.
REQ-036 Reset abort: rst_n low during TIMING -> outputs at reset values, no strobe, start pulses while busy ignored, new run completes normally.

Source files
------------

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 reaction-timer controller.
// Holds the controller state encoding, the "no result" sentinel and the default timeout.
// Also provides a small min helper used for best-time tracking.
package f1_pkg;

    // Controller states. IDLE must stay the reset/encoding-zero state.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_SEQ    = 3'd2,
        ST_HOLD   = 3'd3,
        ST_TIMING = 3'd4,
        ST_DONE   = 3'd5,
        ST_FOUL   = 3'd6
    } state_t;

    // Reaction value reported on timeout, and the "no best yet" value of best_ms.
    localparam logic [15:0] MS_SENTINEL = 16'hFFFF;

    // Default reaction-window limit in ms ticks (legal range 1..65534).
    localparam int unsigned DEFAULT_TIMEOUT_MS = 2000;

    // Lamp patterns that gate the sequence.
    localparam logic [7:0] LIGHTS_ALL_ON  = 8'hFF;
    localparam logic [7:0] LIGHTS_ALL_OFF = 8'h00;

    // Strict minimum: on a tie the first operand (current best) is kept.
    function automatic logic [15:0] min16(input logic [15:0] cur, input logic [15:0] cand);
        return (cand < cur) ? cand : cur;
    endfunction

endpackage

// File: rtl/ms_counter.sv
// Millisecond counter for the reaction window: synchronous clear, +1 per tick while run.
// Latency: count_inc/hit are combinational from the current count and tick.
// No backpressure; tick is a free-running strobe and is never stalled.
//
// Ports:
//   clk, rst_n   - system clock, async active-low reset
//   clear        - force the count to 0 on the next edge (wins over run)
//   run          - enable counting on tick
//   tick         - one-cycle 1 ms strobe
//   count_inc    - count plus a coincident tick (the value a press this cycle reports)
//   hit          - this tick brings the count to the timeout limit
module ms_counter
    import f1_pkg::*;
#(
    parameter int unsigned TIMEOUT_MS = DEFAULT_TIMEOUT_MS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        run,
    input  logic        tick,
    output logic [15:0] count_inc,
    output logic        hit
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_MS);

    logic [15:0] count;

    // The limit never exceeds 65534, so count_inc cannot wrap while running.
    assign count_inc = count + {15'd0, tick};

    // Only a tick can move the count onto the limit, so compare the post-tick value.
    assign hit = run && tick && (count_inc == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'd0;
        end else if (clear) begin
            count <= 16'd0;
        end else if (run && tick) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/f1_reaction_ctrl.sv
// F1 reaction-time controller: arms the light sequence, times the driver's press, tracks best.
// Latency: result strobes one cycle after the deciding press/tick; best_ms one cycle after valid.
// No backpressure: start is ignored while busy, result strobes are single-cycle and unacknowledged.
//
// Ports:
//   clk, rst_n           - system clock, async active-low reset
//   start, react, tick   - arm request, driver button (level), 1 ms strobe
//   lights               - lamp vector from the light-sequence FSM
//   trigger              - one-cycle start pulse to the light-sequence FSM
//   reaction_ms, best_ms - last measured time, minimum valid time since reset
//   valid, false_start, timeout - one-cycle result strobes
//   busy                 - high whenever not IDLE
module f1_reaction_ctrl
    import f1_pkg::*;
#(
    parameter int unsigned TIMEOUT_MS = DEFAULT_TIMEOUT_MS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        react,
    input  logic        tick,
    input  logic [7:0]  lights,
    output logic        trigger,
    output logic [15:0] reaction_ms,
    output logic        valid,
    output logic        false_start,
    output logic        timeout,
    output logic [15:0] best_ms,
    output logic        busy
);

    state_t      state;
    state_t      state_nxt;

    logic        react_q;
    logic        react_rise;

    logic        cnt_clear;
    logic        cnt_run;
    logic [15:0] cnt_inc;
    logic        cnt_hit;

    logic        load_react;
    logic        load_timeout;
    logic        to_flag;

    // A held button must not count as a new press; only the rising edge does.
    assign react_rise = react && !react_q;

    ms_counter #(
        .TIMEOUT_MS (TIMEOUT_MS)
    ) u_ms_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (cnt_clear),
        .run       (cnt_run),
        .tick      (tick),
        .count_inc (cnt_inc),
        .hit       (cnt_hit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and Moore outputs.
    always_comb begin
        state_nxt    = state;
        trigger      = 1'b0;
        valid        = 1'b0;
        false_start  = 1'b0;
        timeout      = 1'b0;
        busy         = 1'b1;
        cnt_clear    = 1'b0;
        cnt_run      = 1'b0;
        load_react   = 1'b0;
        load_timeout = 1'b0;

        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ST_ARM;
                end
            end

            ST_ARM: begin
                trigger   = 1'b1;
                state_nxt = ST_SEQ;
            end

            ST_SEQ: begin
                if (react_rise) begin
                    state_nxt = ST_FOUL;
                end else if (lights == LIGHTS_ALL_ON) begin
                    state_nxt = ST_HOLD;
                end
            end

            ST_HOLD: begin
                // A press in the same cycle the lamps go out is still early.
                if (react_rise) begin
                    state_nxt = ST_FOUL;
                end else if (lights == LIGHTS_ALL_OFF) begin
                    cnt_clear = 1'b1;
                    state_nxt = ST_TIMING;
                end
            end

            ST_TIMING: begin
                cnt_run = 1'b1;
                // A press beats a coincident timeout tick: the driver did react in time.
                if (react_rise) begin
                    load_react = 1'b1;
                    state_nxt  = ST_DONE;
                end else if (cnt_hit) begin
                    load_timeout = 1'b1;
                    state_nxt    = ST_DONE;
                end
            end

            ST_DONE: begin
                valid     = 1'b1;
                timeout   = to_flag;
                state_nxt = ST_IDLE;
            end

            ST_FOUL: begin
                false_start = 1'b1;
                state_nxt   = ST_IDLE;
            end

            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Button history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            react_q <= 1'b0;
        end else begin
            react_q <= react;
        end
    end

    // Result registers: loaded on the edge that enters DONE, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reaction_ms <= 16'd0;
            to_flag     <= 1'b0;
        end else if (load_react) begin
            reaction_ms <= cnt_inc;
            to_flag     <= 1'b0;
        end else if (load_timeout) begin
            reaction_ms <= MS_SENTINEL;
            to_flag     <= 1'b1;
        end
    end

    // Best time follows valid by one cycle; timeouts never qualify.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_ms <= MS_SENTINEL;
        end else if (state == ST_DONE && !to_flag) begin
            best_ms <= min16(best_ms, reaction_ms);
        end
    end

endmodule
